// File: rtl/adder_pkg.sv
// Shared constants and parameter helpers for the pipelined adder.
package adder_pkg;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

  // Slice width, or 0 when the operand width does not split evenly into the stages.
  function automatic int unsigned slice_width(int unsigned width, int unsigned stages);
    if (stages == 0 || (width % stages) != 0) begin
      return 0;
    end
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One carry-chained pipeline stage: adds its CW-bit slice and carries the rest of the operation.
module adder_slice
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] bp_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] bp_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o
);

  logic             valid_q;
  logic [WIDTH-1:0] a_q, bp_q, sum_q, sum_d;
  logic             carry_q, ovf_q, zero_q, ovf_d, zero_d;
  logic [CW:0]      slice_sum;

  assign ready_o = !valid_q | ready_i;

  always_comb begin
    slice_sum = {1'b0, a_i[IDX*CW +: CW]} + {1'b0, bp_i[IDX*CW +: CW]} + {{CW{1'b0}}, carry_i};
    sum_d = sum_i;
    sum_d[IDX*CW +: CW] = slice_sum[CW-1:0];
    // Flags only mean something once every slice is filled in, i.e. in the last stage.
    ovf_d  = (a_i[WIDTH-1] == bp_i[WIDTH-1]) & (sum_d[WIDTH-1] != a_i[WIDTH-1]);
    zero_d = ~|sum_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      bp_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        a_q     <= a_i;
        bp_q    <= bp_i;
        sum_q   <= sum_d;
        carry_q <= slice_sum[CW];
        ovf_q   <= ovf_d;
        zero_q  <= zero_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign bp_o    = bp_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/pipelined_adder.sv
// Skewed, carry-chained add/subtract pipeline with valid/ready flow control and ALU flags.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = slice_width(WIDTH, STAGES);

  if (CW == 0) begin : gen_bad_params
    $error("WIDTH must be a nonzero multiple of STAGES");
  end

  // Index k is the input of stage k; index STAGES is the output of the last stage.
  logic [STAGES:0]  valid_w, ready_w, carry_w;
  logic [STAGES:1]  ovf_w, zero_w;
  logic [WIDTH-1:0] a_w   [STAGES+1];
  logic [WIDTH-1:0] bp_w  [STAGES+1];
  logic [WIDTH-1:0] sum_w [STAGES+1];

  assign valid_w[0]      = in_valid;
  assign in_ready        = ready_w[0];
  assign ready_w[STAGES] = out_ready;
  assign a_w[0]          = a;
  assign bp_w[0]         = (sub == OpAdd) ? b : ~b;
  assign sum_w[0]        = '0;
  assign carry_w[0]      = cin ^ (sub == OpSub);

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    adder_slice #(
      .WIDTH(WIDTH),
      .CW   (CW),
      .IDX  (k)
    ) u_slice (
      .clk_i  (clk),
      .rst_ni (rstn),
      .valid_i(valid_w[k]),
      .ready_o(ready_w[k]),
      .a_i    (a_w[k]),
      .bp_i   (bp_w[k]),
      .sum_i  (sum_w[k]),
      .carry_i(carry_w[k]),
      .valid_o(valid_w[k+1]),
      .ready_i(ready_w[k+1]),
      .a_o    (a_w[k+1]),
      .bp_o   (bp_w[k+1]),
      .sum_o  (sum_w[k+1]),
      .carry_o(carry_w[k+1]),
      .ovf_o  (ovf_w[k+1]),
      .zero_o (zero_w[k+1])
    );
  end

  assign out_valid = valid_w[STAGES];
  assign sum       = sum_w[STAGES];
  assign cout      = carry_w[STAGES];
  assign overflow  = ovf_w[STAGES];
  assign zero      = zero_w[STAGES];

  // Operand payload leaving the last stage and flags of inner stages have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_w[STAGES], bp_w[STAGES], ovf_w, zero_w};

endmodule
